// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester, memory and status signals of the data-memory port arbiter
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [CNT_W-1:0]  conflict_cnt;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conflict_cnt
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conflict_cnt
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - round-robin arbiter sharing one data memory between CPU and host ports
module dmem_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_port_arbiter_if.slave   bus
);
    // rr_ptr = 0 favours port 0, 1 favours port 1
    logic             rr_ptr;
    logic             rd_pend;
    logic             rd_owner;
    logic [CNT_W-1:0] cnt;
    logic             gnt0;
    logic             gnt1;
    logic             both_req;

    assign both_req = bus.m0_req & bus.m1_req;

    // Grant: a lone requester always wins, under contention the favoured port wins
    always_comb begin
        gnt0 = bus.m0_req & (~bus.m1_req | ~rr_ptr);
        gnt1 = bus.m1_req & (~bus.m0_req |  rr_ptr);
    end

    assign bus.m0_gnt = gnt0;
    assign bus.m1_gnt = gnt1;

    // Steer the granted port onto the memory; all zero when idle
    always_comb begin
        bus.mem_en    = gnt0 | gnt1;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (gnt0) begin
            bus.mem_we    = bus.m0_we;
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
        end else if (gnt1) begin
            bus.mem_we    = bus.m1_we;
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
        end
    end

    // Round-robin pointer: after any grant, favour the other port
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end

    // Read tracking: reloaded every edge so back-to-back reads run at full rate
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend  <= (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);
            rd_owner <= gnt1;
        end
    end

    // Saturating count of cycles where both ports asked for the memory
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (both_req && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.conflict_cnt = cnt;

    // Return read data to the owning port only; the other port sees zeros
    always_comb begin
        bus.m0_rvalid = rd_pend & ~rd_owner;
        bus.m1_rvalid = rd_pend &  rd_owner;
        bus.m0_rdata  = bus.m0_rvalid ? bus.mem_rdata : '0;
        bus.m1_rdata  = bus.m1_rvalid ? bus.mem_rdata : '0;
    end
endmodule
